// File: rtl/psum_drain.sv
// Column partial-sum drain: accumulates K psums per result and queues results.
// Define PSUM_DRAIN_SAT_EN to saturate the accumulator instead of wrapping.
module psum_drain #(
    parameter int DATA_W = 24,
    parameter int ACC_W  = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        num_tiles,
    input  logic [7:0]        num_results,
    input  logic              psum_valid,
    input  logic [DATA_W-1:0] psum_in,
    output logic              psum_ready,
    output logic              res_valid,
    output logic [ACC_W-1:0]  res_data,
    output logic              res_last,
    input  logic              res_ready,
    output logic              busy,
    output logic              done,
    output logic              overflow
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DRAIN
    } state_t;

    state_t           state_q;
    logic [7:0]       tiles_q;
    logic [7:0]       results_q;
    logic [7:0]       tile_cnt_q;
    logic [7:0]       res_cnt_q;
    logic [ACC_W-1:0] acc_q;
    logic             ovf_q;
    logic             done_q;

    logic [ACC_W:0]   mem_q [DEPTH];
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    rd_q;
    logic [AW:0]      cnt_q;

    logic             full;
    logic             accept;
    logic             last_tile;
    logic             last_res;
    logic             push;
    logic             pop;
    logic [ACC_W:0]   sum;
    logic             carry;
    logic [ACC_W-1:0] acc_d;

    assign full      = (cnt_q == (AW+1)'(DEPTH));
    assign accept    = (state_q == ACCUM) && !full && psum_valid;
    assign last_tile = (tile_cnt_q == tiles_q - 8'd1);
    assign last_res  = (res_cnt_q == results_q - 8'd1);
    assign push      = accept && last_tile;
    assign pop       = (cnt_q != '0) && res_ready;

    assign sum   = {1'b0, acc_q} + (ACC_W+1)'(psum_in);
    assign carry = sum[ACC_W];

`ifdef PSUM_DRAIN_SAT_EN
    // Once saturated, any further nonzero psum carries again and re-saturates.
    assign acc_d = carry ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
    assign acc_d = sum[ACC_W-1:0];
`endif

    assign psum_ready = (state_q == ACCUM) && !full;
    assign res_valid  = (cnt_q != '0);
    assign res_data   = mem_q[rd_q][ACC_W-1:0];
    assign res_last   = mem_q[rd_q][ACC_W];
    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign overflow   = ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tiles_q    <= 8'd1;
            results_q  <= 8'd1;
            tile_cnt_q <= '0;
            res_cnt_q  <= '0;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        tiles_q    <= (num_tiles == '0) ? 8'd1 : num_tiles;
                        results_q  <= (num_results == '0) ? 8'd1 : num_results;
                        tile_cnt_q <= '0;
                        res_cnt_q  <= '0;
                        acc_q      <= '0;
                        ovf_q      <= 1'b0;
                        state_q    <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        if (carry) ovf_q <= 1'b1;
                        if (last_tile) begin
                            acc_q      <= '0;
                            tile_cnt_q <= '0;
                            res_cnt_q  <= res_cnt_q + 8'd1;
                            if (last_res) state_q <= DRAIN;
                        end else begin
                            acc_q      <= acc_d;
                            tile_cnt_q <= tile_cnt_q + 8'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && cnt_q == (AW+1)'(1)) begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_q] <= {last_res, acc_d};
                wr_q        <= wr_q + AW'(1);
            end
            if (pop) rd_q <= rd_q + AW'(1);
            unique case ({push, pop})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: doc/psum_drain.md
Name: psum_drain

Overview:
- Sits below the last MAC cell of one systolic-array column and drains the 24-bit partial sums the column produces.
- Accumulates a programmable number of partial sums (K tiles) into each ACC_W-bit result.
- Buffers finished results in a small FIFO and streams them to the output writer over a valid/ready handshake.
- Applies backpressure to the array controller when the FIFO is full.

Parameters:
- DATA_W, 24, partial-sum width from the column.
- ACC_W, 32, accumulator/result width (must be >= DATA_W).
- DEPTH, 4, result FIFO entries (power of 2, >= 2).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle job start; latches num_tiles and num_results.
- num_tiles  in  8  partial sums per result; 0 treated as 1.
- num_results  in  8  results per job; 0 treated as 1.
- psum_valid  in  1  psum_in valid.
- psum_in  in  DATA_W  partial sum from the column bottom, unsigned.
- psum_ready  out  1  drain can accept psum this cycle.
- res_valid  out  1  FIFO head valid.
- res_data  out  ACC_W  FIFO head result.
- res_last  out  1  head is the final result of the job.
- res_ready  in  1  consumer accepts the head.
- busy  out  1  job in progress.
- done  out  1  one-cycle pulse at job completion.
- overflow  out  1  sticky accumulate overflow; cleared by start.

Behaviour:
- Reset (async, rst_n=0): state IDLE; acc, tile_cnt, res_cnt = 0; FIFO empty. All outputs 0: psum_ready, res_valid, res_data, res_last, busy, done, overflow. Reset mid-job discards all state and buffered results.
- IDLE: busy=0, psum_ready=0.
  - start=1: latch max(num_tiles,1) and max(num_results,1); clear acc, counters and overflow; go ACCUM next cycle.
- ACCUM: busy=1; psum_ready = !fifo_full (registered full flag; a same-cycle pop does not raise ready).
  - Accept occurs when psum_valid && psum_ready.
  - Not the last tile: acc <= acc + zext(psum_in); tile_cnt++.
  - Last tile (tile_cnt == tiles-1): push acc + zext(psum_in) into the FIFO; acc <= 0; tile_cnt <= 0; res_cnt++.
    - Pushed entry carries last=1 when res_cnt == results-1; in that case go DRAIN.
- DRAIN: psum_ready=0, busy=1.
  - When the FIFO becomes empty (last entry popped), pulse done for 1 cycle and go IDLE; busy drops in the same cycle done is high.
- start is ignored while busy=1.
- Arithmetic: psum zero-extended to ACC_W; sum wraps modulo 2^ACC_W. Any carry-out sets overflow, which stays set until the next start.
- FIFO:
  - Registered head: res_valid/res_data/res_last are valid the cycle after the push that fills an empty FIFO (1-cycle latency from final psum accept to res_valid).
  - Pop when res_valid && res_ready.
  - Simultaneous push and pop is legal at any occupancy below full; occupancy is unchanged.
  - res_data and res_last hold stable while res_valid=1 and res_ready=0.
- num_tiles=1: every accepted psum produces a result (pass-through with ACC_W extension).

Optional Feature:
- Macro PSUM_DRAIN_SAT_EN.
- Defined: on carry-out the accumulator saturates to all-ones (2^ACC_W-1) and stays saturated for the rest of that result; overflow is still set.
- Undefined: modulo wrap as described above.
- Port list is identical in both builds.

Test Plan:
- Basic: start, num_tiles=3, num_results=2; psums 10,20,30,1,2,3, res_ready=1 → results 60 then 6; res_last=1 on 6 only; done pulses once after 6 is popped; overflow=0.
- Backpressure: DEPTH=4, num_tiles=1, num_results=6, res_ready=0; stream 6 psums → psum_ready=0 after 4 accepts; release res_ready → remaining 2 accepted; outputs appear in order with no loss or duplication.
- Overflow, ACC_W=24 build: num_tiles=2, psums 0xFFFFFF and 0x000002 → wrap build: result 0x000001, overflow=1; PSUM_DRAIN_SAT_EN build: result 0xFFFFFF, overflow=1; next start clears overflow.
- Zero config: num_tiles=0, num_results=0, single psum 7 → one result 7 with res_last=1; done pulses.
- Reset mid-job: rst_n low after 2 of 3 tiles with one result buffered → all outputs 0 immediately; after release a new job computes from acc=0.
- start while busy, plus simultaneous push/pop at full-1 occupancy → start has no effect; occupancy unchanged; data order preserved.
